// File: rtl/xcorr_peak_detect.sv
// Peak search over a fixed window of complex correlation sums.
// Approximate magnitude max(|I|,|Q|) + min(|I|,|Q|)/4, earliest index wins ties.
module xcorr_peak_detect #(
  parameter int unsigned WINDOW_LEN = 64,
  parameter int unsigned IDX_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [63:0]          sum_in,
  input  logic                 input_strobe,
  input  logic                 search_start,
  input  logic [31:0]          threshold,
  output logic [IDX_WIDTH-1:0] peak_index,
  output logic [31:0]          peak_mag,
  output logic                 peak_valid,
  output logic                 output_strobe,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StSearch, StDrain, StReport} state_t;

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(WINDOW_LEN - 1);

  state_t               r_state;
  logic [IDX_WIDTH-1:0] r_cnt;
  logic [31:0]          r_thr;
  logic [31:0]          r_max;
  logic [IDX_WIDTH-1:0] r_max_idx;

  logic [31:0]          r_p1_a, r_p1_b;
  logic [IDX_WIDTH-1:0] r_p1_idx;
  logic                 r_p1_vld;
  logic [31:0]          r_p2_mag;
  logic [IDX_WIDTH-1:0] r_p2_idx;
  logic                 r_p2_vld;

  logic [IDX_WIDTH-1:0] r_peak_index;
  logic [31:0]          r_peak_mag;
  logic                 r_peak_valid;
  logic                 r_out_strobe;

  logic [31:0]          w_i, w_q, w_abs_i, w_abs_q;
  logic [31:0]          w_hi, w_lo, w_mag;
  logic                 w_accept;
  logic [IDX_WIDTH-1:0] w_idx;

  // Two's-complement negate yields 0x80000000 for -2^31, which is the exact magnitude.
  assign w_i     = sum_in[63:32];
  assign w_q     = sum_in[31:0];
  assign w_abs_i = w_i[31] ? (~w_i + 32'd1) : w_i;
  assign w_abs_q = w_q[31] ? (~w_q + 32'd1) : w_q;

  assign w_hi  = (r_p1_a >= r_p1_b) ? r_p1_a : r_p1_b;
  assign w_lo  = (r_p1_a >= r_p1_b) ? r_p1_b : r_p1_a;
  assign w_mag = w_hi + (w_lo >> 2);

  // A search_start cycle accepts its own strobe as index 0 of the new window.
  assign w_accept = input_strobe && (search_start || (r_state == StSearch));
  assign w_idx    = search_start ? '0 : r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_thr        <= '0;
      r_max        <= '0;
      r_max_idx    <= '0;
      r_p1_a       <= '0;
      r_p1_b       <= '0;
      r_p1_idx     <= '0;
      r_p1_vld     <= 1'b0;
      r_p2_mag     <= '0;
      r_p2_idx     <= '0;
      r_p2_vld     <= 1'b0;
      r_peak_index <= '0;
      r_peak_mag   <= '0;
      r_peak_valid <= 1'b0;
      r_out_strobe <= 1'b0;
    end else if (enable) begin
      r_p1_a       <= w_abs_i;
      r_p1_b       <= w_abs_q;
      r_p1_idx     <= w_idx;
      r_p1_vld     <= w_accept;
      r_p2_mag     <= w_mag;
      r_p2_idx     <= r_p1_idx;
      r_p2_vld     <= r_p1_vld && !search_start;
      r_out_strobe <= 1'b0;

      if (search_start) begin
        r_thr     <= threshold;
        r_max     <= '0;
        r_max_idx <= '0;
        r_cnt     <= input_strobe ? IDX_WIDTH'(1) : '0;
        r_state   <= (input_strobe && (LastIdx == '0)) ? StDrain : StSearch;
      end else begin
        if (r_p2_vld && (r_p2_mag > r_max)) begin
          r_max     <= r_p2_mag;
          r_max_idx <= r_p2_idx;
        end
        case (r_state)
          StIdle: ;
          StSearch: begin
            if (input_strobe) begin
              r_cnt <= r_cnt + IDX_WIDTH'(1);
              if (r_cnt == LastIdx) r_state <= StDrain;
            end
          end
          StDrain: begin
            if (r_p2_vld && (r_p2_idx == LastIdx)) r_state <= StReport;
          end
          StReport: begin
            r_peak_index <= r_max_idx;
            r_peak_mag   <= r_max;
            r_peak_valid <= (r_max >= r_thr);
            r_out_strobe <= 1'b1;
            r_state      <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign peak_index    = r_peak_index;
  assign peak_mag      = r_peak_mag;
  assign peak_valid    = r_peak_valid;
  assign output_strobe = r_out_strobe;
  assign busy          = (r_state == StSearch) || (r_state == StDrain);

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Bench for xcorr_peak_detect: 4- and 64-sample instances against a plain-arithmetic model.
module tb_xcorr_peak_detect;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [63:0] sum_in = '0;
  logic        input_strobe = 1'b0;
  logic        search_start = 1'b0;
  logic [31:0] threshold = '0;

  logic [7:0]  idx4, idx64;
  logic [31:0] mag4, mag64;
  logic        vld4, vld64, ostb4, ostb64, busy4, busy64;

  xcorr_peak_detect #(.WINDOW_LEN(4), .IDX_WIDTH(8)) u_dut4 (
    .clock(clock), .reset(reset), .enable(enable), .sum_in(sum_in),
    .input_strobe(input_strobe), .search_start(search_start), .threshold(threshold),
    .peak_index(idx4), .peak_mag(mag4), .peak_valid(vld4),
    .output_strobe(ostb4), .busy(busy4)
  );

  xcorr_peak_detect #(.WINDOW_LEN(64), .IDX_WIDTH(8)) u_dut64 (
    .clock(clock), .reset(reset), .enable(enable), .sum_in(sum_in),
    .input_strobe(input_strobe), .search_start(search_start), .threshold(threshold),
    .peak_index(idx64), .peak_mag(mag64), .peak_valid(vld64),
    .output_strobe(ostb64), .busy(busy64)
  );

  always #5 clock = ~clock;

  bit          sel;  // 0: 4-sample instance, 1: 64-sample instance
  logic [7:0]  w_idx;
  logic [31:0] w_mag;
  logic        w_vld, w_ostb, w_busy;
  assign w_idx  = sel ? idx64  : idx4;
  assign w_mag  = sel ? mag64  : mag4;
  assign w_vld  = sel ? vld64  : vld4;
  assign w_ostb = sel ? ostb64 : ostb4;
  assign w_busy = sel ? busy64 : busy4;

  int cnt4 = 0, cnt64 = 0;
  always @(negedge clock) begin
    if (ostb4 === 1'b1)  cnt4  = cnt4 + 1;
    if (ostb64 === 1'b1) cnt64 = cnt64 + 1;
  end

  int n_vec = 0, n_err = 0;

  logic signed [31:0] s_i [64];
  logic signed [31:0] s_q [64];

  typedef struct {
    logic signed [31:0] i;
    logic signed [31:0] q;
    logic [31:0]        thr;
    logic [31:0]        mag;
    logic [7:0]         idx;
    bit                 vld;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic longint mag_of(logic signed [31:0] i, logic signed [31:0] q);
    longint ai, aq, hi, lo;
    ai = (i < 0) ? -longint'(i) : longint'(i);
    aq = (q < 0) ? -longint'(q) : longint'(q);
    hi = (ai > aq) ? ai : aq;
    lo = (ai > aq) ? aq : ai;
    return hi + lo / 4;
  endfunction

  task automatic model_peak(input int wl, input logic [31:0] thr,
                            output int idx, output logic [31:0] mag, output bit v);
    longint best = 0;
    idx = 0;
    for (int k = 0; k < wl; k++) begin
      if (mag_of(s_i[k], s_q[k]) > best) begin
        best = mag_of(s_i[k], s_q[k]);
        idx  = k;
      end
    end
    mag = best[31:0];
    v   = (best >= longint'(thr));
  endtask

  // Drives one full window (index 0 rides on search_start) and checks the report.
  task automatic run_window(input int wl, input logic [31:0] thr, input int gap,
                            input int hole_at, input bit post_stb, input string tag);
    int          c0, lat, e_idx;
    bit          busy_ok, e_v;
    logic [31:0] e_mag;
    model_peak(wl, thr, e_idx, e_mag, e_v);
    c0 = sel ? cnt64 : cnt4;
    search_start = 1'b1;
    threshold    = thr;
    input_strobe = 1'b1;
    sum_in       = {s_i[0], s_q[0]};
    step();
    search_start = 1'b0;
    threshold    = $urandom;
    for (int k = 1; k < wl; k++) begin
      for (int g = 1; g < gap; g++) begin
        input_strobe = 1'b0;
        sum_in       = {$urandom, $urandom};
        step();
      end
      if (k == hole_at) begin
        enable       = 1'b0;
        input_strobe = 1'b1;
        sum_in       = {32'sh7fffffff, 32'sh7fffffff};
        repeat (5) step();
        enable = 1'b1;
      end
      input_strobe = 1'b1;
      sum_in       = {s_i[k], s_q[k]};
      step();
    end
    input_strobe = post_stb;
    sum_in       = {32'sh7fff0000, 32'sh0};
    lat     = 0;
    busy_ok = 1'b1;
    while (!w_ostb && lat < 20) begin
      if (lat < 2 && !w_busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    input_strobe = 1'b0;
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_busy"}, busy_ok, 1);
    chk({tag, "_idx"}, w_idx, e_idx);
    chk({tag, "_mag"}, w_mag, e_mag);
    chk({tag, "_valid"}, w_vld, e_v);
    step();
    chk({tag, "_one_pulse"}, w_ostb, 0);
    chk({tag, "_strobe_count"}, (sel ? cnt64 : cnt4) - c0, 1);
  endtask

  task automatic clear_samples();
    for (int k = 0; k < 64; k++) begin
      s_i[k] = '0;
      s_q[k] = '0;
    end
  endtask

  task automatic rand_samples(input int wl);
    for (int k = 0; k < wl; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        s_i[k] = ($urandom_range(0, 1) == 1) ? 32'sh80000000 : 32'sh7fffffff;
        s_q[k] = $signed($urandom) >>> $urandom_range(0, 31);
      end else if (r == 1 && k > 0) begin
        s_i[k] = s_i[k-1 - int'($urandom_range(0, k-1))];
        s_q[k] = 0;
        s_q[k] = s_q[k];
      end else begin
        s_i[k] = $signed($urandom) >>> $urandom_range(0, 31);
        s_q[k] = $signed($urandom) >>> $urandom_range(0, 31);
      end
    end
  endtask

  initial begin
    int          ri, base_idx;
    logic [31:0] rm, thr, base_mag;
    bit          rv, base_v;
    int          c0;

    tbl[0] = '{-32'sd400, 32'sd100, 32'd425, 32'd425, 8'd2, 1'b1};
    tbl[1] = '{32'sd3, -32'sd4, 32'd5, 32'd4, 8'd2, 1'b0};
    tbl[2] = '{32'sh80000000, 32'sd0, 32'd0, 32'h80000000, 8'd2, 1'b1};
    tbl[3] = '{32'sh80000000, 32'sh80000000, 32'hA0000001, 32'hA0000000, 8'd2, 1'b0};
    tbl[4] = '{32'sh7fffffff, 32'sd7, 32'd1, 32'h80000000, 8'd2, 1'b1};
    tbl[5] = '{32'sd500, -32'sd500, 32'd625, 32'd625, 8'd2, 1'b1};
    tbl[6] = '{32'sd0, -32'sd9, 32'd10, 32'd9, 8'd2, 1'b0};
    tbl[7] = '{32'sd0, 32'sd0, 32'd0, 32'd0, 8'd0, 1'b1};
    tbl[8] = '{32'sd0, 32'sd0, 32'd1, 32'd0, 8'd0, 1'b0};
    tbl[9] = '{-32'sd5, -32'sd20, 32'd21, 32'd21, 8'd2, 1'b1};

    // Reset state of both instances
    repeat (3) step();
    reset = 1'b0;
    chk("rst_idx4", idx4, 0);
    chk("rst_mag4", mag4, 0);
    chk("rst_vld4", vld4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_idx64", idx64, 0);
    chk("rst_mag64", mag64, 0);
    chk("rst_vld64", vld64, 0);
    chk("rst_ostb64", ostb64, 0);
    chk("rst_busy64", busy64, 0);

    // Table: single sample at index 2 of a 4-sample window
    sel = 1'b0;
    for (int v = 0; v < 10; v++) begin
      clear_samples();
      s_i[2] = tbl[v].i;
      s_q[2] = tbl[v].q;
      run_window(4, tbl[v].thr, 1, -1, 1'b0, $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d_const_mag", v), w_mag, tbl[v].mag);
      chk($sformatf("tbl%0d_const_idx", v), w_idx, tbl[v].idx);
      chk($sformatf("tbl%0d_const_vld", v), w_vld, tbl[v].vld);
    end

    // Mixed 4-sample window, peak at last index
    clear_samples();
    s_i[0] = -32'sd400; s_q[0] = 32'sd100;
    s_i[1] = 32'sd3;    s_q[1] = -32'sd4;
    s_i[3] = 32'sh80000000;
    run_window(4, 32'd0, 1, -1, 1'b0, "mag4");
    chk("mag4_const_idx", w_idx, 3);
    chk("mag4_const_mag", w_mag, 32'h80000000);

    // Tie + threshold miss
    sel = 1'b1;
    for (int k = 0; k < 64; k++) begin
      s_i[k] = 32'sd100;
      s_q[k] = 32'sd0;
    end
    s_i[10] = 32'sd500; s_q[10] = -32'sd500;
    s_i[40] = 32'sd500; s_q[40] = -32'sd500;
    run_window(64, 32'd700, 1, -1, 1'b0, "tie");
    chk("tie_const_idx", w_idx, 10);
    chk("tie_const_mag", w_mag, 625);
    chk("tie_const_vld", w_vld, 0);

    // Same-cycle start; trailing strobes must not disturb the result
    clear_samples();
    s_i[0] = 32'sd1000;
    run_window(64, 32'd0, 1, -1, 1'b1, "same");
    chk("same_const_idx", w_idx, 0);
    chk("same_const_mag", w_mag, 1000);

    // Abort at index 20, then a full second window
    for (int k = 0; k < 64; k++) begin
      s_i[k] = 32'sd50;
      s_q[k] = 32'sd0;
    end
    s_i[5] = 32'sd9000;
    c0 = cnt64;
    search_start = 1'b1;
    threshold    = 32'd1;
    for (int k = 0; k < 20; k++) begin
      input_strobe = 1'b1;
      sum_in       = {s_i[k], s_q[k]};
      step();
      search_start = 1'b0;
    end
    for (int k = 0; k < 64; k++) begin
      s_i[k] = 32'sd30;
      s_q[k] = -32'sd30;
    end
    s_i[7] = 32'sd20000; s_q[7] = 32'sd5;
    run_window(64, 32'd100, 1, -1, 1'b0, "restart");
    chk("restart_const_idx", w_idx, 7);
    chk("restart_total_reports", cnt64 - c0, 1);

    // Gaps and enable hole must match the back-to-back result
    rand_samples(64);
    thr = $urandom;
    run_window(64, thr, 1, -1, 1'b0, "b2b");
    base_idx = w_idx; base_mag = w_mag; base_v = w_vld;
    run_window(64, thr, 3, 30, 1'b0, "gap");
    chk("gap_same_idx", w_idx, base_idx);
    chk("gap_same_mag", w_mag, base_mag);
    chk("gap_same_vld", w_vld, base_v);

    // Reset during DRAIN
    clear_samples();
    s_i[9] = 32'sd777;
    c0 = cnt64;
    search_start = 1'b1;
    threshold    = 32'd0;
    for (int k = 0; k < 64; k++) begin
      input_strobe = 1'b1;
      sum_in       = {s_i[k], s_q[k]};
      step();
      search_start = 1'b0;
    end
    input_strobe = 1'b0;
    chk("drain_busy", busy64, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstd_idx", idx64, 0);
    chk("rstd_mag", mag64, 0);
    chk("rstd_vld", vld64, 0);
    chk("rstd_ostb", ostb64, 0);
    chk("rstd_busy", busy64, 0);
    repeat (8) step();
    chk("rstd_no_report", cnt64 - c0, 0);
    run_window(64, 32'd777, 1, -1, 1'b0, "after_rst");

    // Randomized windows on both instances
    for (int n = 0; n < 12; n++) begin
      sel = (n % 2 == 1);
      rand_samples(sel ? 64 : 4);
      model_peak(sel ? 64 : 4, 32'd0, ri, rm, rv);
      case ($urandom_range(0, 3))
        0: thr = 32'd0;
        1: thr = rm;
        2: thr = rm + 32'd1;
        default: thr = $urandom;
      endcase
      run_window(sel ? 64 : 4, thr, int'($urandom_range(1, 3)),
                 int'($urandom_range(1, sel ? 63 : 3)), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
